// File: rtl/ftdi_bus_arbiter_if.sv
// ftdi_bus_arbiter_if: bundle of the FT245-style pin signals plus the
// receive and two transmit handshakes served by ftdi_bus_arbiter.
//   master : the arbiter (drives strobes, pad data/enable, rx byte, tx accepts)
//   slave  : the environment (FTDI pins, rx consumer, tx requesters)
// Pins:      rxf_n, txe_n, rd_n, wr_n, oe, dq_o, dq_i
// RX path:   rx_data, rx_valid, rx_ready
// TX paths:  tx0_data/valid/ready, tx1_data/valid/ready
// Status:    busy
interface ftdi_bus_arbiter_if;
    logic       rxf_n;
    logic       txe_n;
    logic       rd_n;
    logic       wr_n;
    logic       oe;
    logic [7:0] dq_o;
    logic [7:0] dq_i;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx0_data;
    logic       tx0_valid;
    logic       tx0_ready;
    logic [7:0] tx1_data;
    logic       tx1_valid;
    logic       tx1_ready;
    logic       busy;

    modport master (
        input  rxf_n, txe_n, dq_i, rx_ready,
        input  tx0_data, tx0_valid, tx1_data, tx1_valid,
        output rd_n, wr_n, oe, dq_o, rx_data, rx_valid,
        output tx0_ready, tx1_ready, busy
    );

    modport slave (
        output rxf_n, txe_n, dq_i, rx_ready,
        output tx0_data, tx0_valid, tx1_data, tx1_valid,
        input  rd_n, wr_n, oe, dq_o, rx_data, rx_valid,
        input  tx0_ready, tx1_ready, busy
    );
endinterface

// File: rtl/ftdi_bus_arbiter.sv
// ftdi_bus_arbiter: time-multiplexes the shared 8-bit FT245 asynchronous FIFO
// bus between one receive path and two round-robin transmit requesters.
// Produces timed rd_n/wr_n strobes, the pad output enable and a bus-released
// turnaround gap after every access; honours rxf_n/txe_n after synchronising.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    ftdi_bus_arbiter_if.master (pins, rx handshake, tx0/tx1 handshakes)
// All outputs are registered.
module ftdi_bus_arbiter #(
    parameter int unsigned RD_PULSE = 3,
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned TURN     = 1,
    parameter int unsigned RX_BURST = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    ftdi_bus_arbiter_if.master bus
);

    localparam int unsigned CNT_MAX = (RD_PULSE > WR_PULSE) ?
                                      ((RD_PULSE > TURN) ? RD_PULSE : TURN) :
                                      ((WR_PULSE > TURN) ? WR_PULSE : TURN);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RUN_W   = (RX_BURST > 0) ? $clog2(RX_BURST + 1) : 1;

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(RX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR,
        S_TURN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] rx_run;
    logic             last_grant;

    logic             rd_n_q;
    logic             wr_n_q;
    logic             oe_q;
    logic [7:0]       dq_o_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             tx0_ready_q;
    logic             tx1_ready_q;
    logic             busy_q;

    // Two-flop synchronisers for the FTDI flow-control flags (idle = high).
    logic rxf_meta, rxf_s;
    logic txe_meta, txe_s;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            rxf_meta <= bus.rxf_n;
            rxf_s    <= rxf_meta;
            txe_meta <= bus.txe_n;
            txe_s    <= txe_meta;
        end
    end

    // Idle-state decision terms.
    logic rx_ok;
    logic tx_ok;
    logic burst_hold;
    logic grant_ch1;

    assign rx_ok      = ~rxf_s & bus.rx_ready;
    assign tx_ok      = (bus.tx0_valid | bus.tx1_valid) & ~txe_s;
    // Reads yield to a pending write once RX_BURST reads have run back to back.
    assign burst_hold = tx_ok & (rx_run == RUN_MAX);
    // Lone requester wins; with both pending the one not served last wins.
    assign grant_ch1  = bus.tx1_valid & (~bus.tx0_valid | ~last_grant);

    // Bus sequencer: state, strobe timing and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rx_run      <= '0;
            last_grant  <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            dq_o_q      <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx0_ready_q <= 1'b0;
            tx1_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx0_ready_q <= 1'b0;
            tx1_ready_q <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!tx_ok) begin
                        rx_run <= '0;
                    end
                    if (rx_ok && !burst_hold) begin
                        state  <= S_RD;
                        rd_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else if (tx_ok) begin
                        // Byte is accepted here; it is sent even if valid drops next cycle.
                        state       <= S_WR_SETUP;
                        oe_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        last_grant  <= grant_ch1;
                        dq_o_q      <= grant_ch1 ? bus.tx1_data : bus.tx0_data;
                        tx0_ready_q <= ~grant_ch1;
                        tx1_ready_q <= grant_ch1;
                    end
                end

                S_RD: begin
                    if (cnt == RD_LAST) begin
                        rd_n_q     <= 1'b1;
                        rx_data_q  <= bus.dq_i;
                        rx_valid_q <= 1'b1;
                        if (rx_run != RUN_MAX) begin
                            rx_run <= rx_run + RUN_W'(1);
                        end
                        cnt   <= '0;
                        state <= S_TURN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_WR_SETUP: begin
                    rx_run <= '0;
                    wr_n_q <= 1'b0;
                    cnt    <= '0;
                    state  <= S_WR;
                end

                S_WR: begin
                    if (cnt == WR_LAST) begin
                        wr_n_q <= 1'b1;
                        oe_q   <= 1'b0;
                        cnt    <= '0;
                        state  <= S_TURN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    rd_n_q <= 1'b1;
                    wr_n_q <= 1'b1;
                    oe_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.oe        = oe_q;
    assign bus.dq_o      = dq_o_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx0_ready = tx0_ready_q;
    assign bus.tx1_ready = tx1_ready_q;
    assign bus.busy      = busy_q;

    // Electrical safety of the shared bus.
    a_strobe_excl: assert property (@(posedge clk) disable iff (!n_rst)
        !(!rd_n_q && !wr_n_q));
    a_rd_released: assert property (@(posedge clk) disable iff (!n_rst)
        oe_q |-> rd_n_q);
    a_busy_state: assert property (@(posedge clk) disable iff (!n_rst)
        busy_q == (state != S_IDLE));

endmodule

// File: tb/tb_ftdi_bus_arbiter.sv
// tb_ftdi_bus_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model that schedules whole accesses
// as queues of expected output frames.
module tb_ftdi_bus_arbiter;

    localparam int RD_PULSE = 3;
    localparam int WR_PULSE = 2;
    localparam int TURN     = 1;
    localparam int RX_BURST = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    ftdi_bus_arbiter_if bus ();

    ftdi_bus_arbiter #(
        .RD_PULSE (RD_PULSE),
        .WR_PULSE (WR_PULSE),
        .TURN     (TURN),
        .RX_BURST (RX_BURST)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic rd_n;
        logic wr_n;
        logic oe;
        logic r0;
        logic r1;
        logic rxv;
        logic busy;
    } frame_t;

    localparam frame_t IDLE_F = 7'b1100000;

    function automatic frame_t mk(input logic rd_n, input logic wr_n, input logic oe,
                                  input logic r0, input logic r1, input logic rxv,
                                  input logic busy);
        frame_t f;
        f.rd_n = rd_n; f.wr_n = wr_n; f.oe = oe;
        f.r0 = r0; f.r1 = r1; f.rxv = rxv; f.busy = busy;
        return f;
    endfunction

    frame_t     plan[$];
    frame_t     cur       = IDLE_F;
    logic [7:0] m_rx_data = 8'h00;
    logic [7:0] m_dq      = 8'h00;
    int         run       = 0;
    bit         last      = 1'b1;
    logic       rxf_a = 1'b1, rxf_b = 1'b1, txe_a = 1'b1, txe_b = 1'b1;

    // When idle, pick the next access and queue its complete output waveform.
    task automatic model_decide();
        bit tx_ok, rx_ok, g;
        tx_ok = (bus.tx0_valid || bus.tx1_valid) && !txe_b;
        rx_ok = !rxf_b && bus.rx_ready;
        if (!tx_ok) run = 0;
        if (rx_ok && !(tx_ok && run == RX_BURST)) begin
            for (int i = 0; i < RD_PULSE; i++) plan.push_back(mk(0, 1, 0, 0, 0, 0, 1));
            for (int i = 0; i < TURN; i++)     plan.push_back(mk(1, 1, 0, 0, 0, i == 0, 1));
            plan.push_back(IDLE_F);
            if (run < RX_BURST) run++;
        end else if (tx_ok) begin
            if (bus.tx0_valid && bus.tx1_valid) g = !last;
            else                                g = bus.tx1_valid;
            last = g;
            m_dq = g ? bus.tx1_data : bus.tx0_data;
            run  = 0;
            plan.push_back(mk(1, 1, 1, !g, g, 0, 1));
            for (int i = 0; i < WR_PULSE; i++) plan.push_back(mk(1, 0, 1, 0, 0, 0, 1));
            for (int i = 0; i < TURN; i++)     plan.push_back(mk(1, 1, 0, 0, 0, 0, 1));
            plan.push_back(IDLE_F);
        end
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            plan.delete();
            cur = IDLE_F; m_rx_data = 8'h00; m_dq = 8'h00; run = 0; last = 1'b1;
            rxf_a = 1'b1; rxf_b = 1'b1; txe_a = 1'b1; txe_b = 1'b1;
        end else begin
            if (plan.size() == 0) model_decide();
            if (plan.size() != 0) cur = plan.pop_front();
            else                  cur = IDLE_F;
            if (cur.rxv) m_rx_data = bus.dq_i;
            rxf_b = rxf_a; rxf_a = bus.rxf_n;
            txe_b = txe_a; txe_a = bus.txe_n;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("rd_n",      32'(bus.rd_n),      32'(cur.rd_n));
        check("wr_n",      32'(bus.wr_n),      32'(cur.wr_n));
        check("oe",        32'(bus.oe),        32'(cur.oe));
        check("tx0_ready", 32'(bus.tx0_ready), 32'(cur.r0));
        check("tx1_ready", 32'(bus.tx1_ready), 32'(cur.r1));
        check("rx_valid",  32'(bus.rx_valid),  32'(cur.rxv));
        check("busy",      32'(bus.busy),      32'(cur.busy));
        check("rx_data",   32'(bus.rx_data),   32'(m_rx_data));
        check("dq_o",      32'(bus.dq_o),      32'(m_dq));
    end

    // ---------------- stimulus ----------------
    int         first, rd_cnt, v_cnt, oe_seen, cnt, lat, stable_err;
    logic [7:0] got, hold;
    logic       prev_wr, prev_rd;
    int         wrs[$], tfall[$], rdy[$], seq[$];
    int         exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int         exp_wr[4]   = '{32'h11, 32'h22, 32'h11, 32'h22};
    int         exp_rdy[4]  = '{0, 1, 0, 1};
    int         rxf_p, txe_p, rdy_p, val_p;

    task automatic idle_pins();
        bus.rxf_n = 1'b1; bus.txe_n = 1'b1; bus.rx_ready = 1'b0; bus.dq_i = 8'h00;
        bus.tx0_valid = 1'b0; bus.tx1_valid = 1'b0;
        bus.tx0_data = 8'h00; bus.tx1_data = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_pins();
        #1 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic requester(input int vp, input logic rdy_in, inout logic valid,
                             inout logic [7:0] data);
        if (rdy_in) begin
            valid = ($urandom_range(0, 99) < vp);
            data  = 8'($urandom);
        end else if (!valid) begin
            if ($urandom_range(0, 99) < vp) begin
                valid = 1'b1;
                data  = 8'($urandom);
            end
        end else if ($urandom_range(0, 99) < 3) begin
            valid = 1'b0;
        end
    endtask

    initial begin
        idle_pins();

        // 1: reset held with random inputs
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.rxf_n = 1'($urandom); bus.txe_n = 1'($urandom);
            bus.rx_ready = 1'($urandom); bus.dq_i = 8'($urandom);
            bus.tx0_valid = 1'($urandom); bus.tx1_valid = 1'($urandom);
            bus.tx0_data = 8'($urandom); bus.tx1_data = 8'($urandom);
        end
        check("t1_rd_n", 32'(bus.rd_n), 32'd1);
        check("t1_wr_n", 32'(bus.wr_n), 32'd1);
        check("t1_oe",   32'(bus.oe),   32'd0);
        check("t1_busy", 32'(bus.busy), 32'd0);
        do_reset();

        // 2: single read
        do_reset();
        bus.rx_ready = 1'b1; bus.dq_i = 8'hA5;
        repeat (3) @(negedge clk);
        bus.rxf_n = 1'b0;
        first = -1; rd_cnt = 0; v_cnt = 0; oe_seen = 0; got = 8'h00;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!bus.rd_n) begin
                rd_cnt++;
                if (first < 0) first = i;
            end
            if (bus.rx_valid) begin
                v_cnt++;
                got = bus.rx_data;
            end
            if (bus.oe) oe_seen = 1;
            if (i == 4) begin
                bus.rxf_n = 1'b1;
                bus.rx_ready = 1'b0;
            end
        end
        check("t2_rd_len",   rd_cnt,    3);
        check("t2_rd_start", first,     3);
        check("t2_rxv_cnt",  v_cnt,     1);
        check("t2_rx_data",  32'(got),  32'hA5);
        check("t2_oe",       oe_seen,   0);

        // 3: round robin between two always-valid channels
        do_reset();
        bus.tx0_data = 8'h11; bus.tx1_data = 8'h22;
        bus.tx0_valid = 1'b1; bus.tx1_valid = 1'b1; bus.txe_n = 1'b0;
        wrs.delete(); tfall.delete(); rdy.delete();
        prev_wr = 1'b1; stable_err = 0; hold = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tx0_ready) rdy.push_back(0);
            if (bus.tx1_ready) rdy.push_back(1);
            if (!bus.wr_n) begin
                if (prev_wr) begin
                    wrs.push_back(int'(bus.dq_o));
                    tfall.push_back(i);
                    hold = bus.dq_o;
                end else if (bus.dq_o !== hold) begin
                    stable_err++;
                end
            end
            prev_wr = bus.wr_n;
        end
        check("t3_num_wr", 32'(wrs.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < wrs.size()) check("t3_wr_data", wrs[k], exp_wr[k]);
            if (k < rdy.size()) check("t3_ready_ch", rdy[k], exp_rdy[k]);
            if (k > 0 && k < tfall.size()) check("t3_period", tfall[k] - tfall[k-1], 5);
        end
        check("t3_dq_stable", stable_err, 0);

        // 4: read bursts interleaved with a pending write
        do_reset();
        bus.rx_ready = 1'b1; bus.tx0_valid = 1'b1; bus.tx0_data = 8'h5A;
        bus.txe_n = 1'b0; bus.rxf_n = 1'b0;
        seq.delete(); wrs.delete();
        prev_rd = 1'b1; prev_wr = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (!bus.rd_n && prev_rd) seq.push_back(0);
            if (!bus.wr_n && prev_wr) begin
                seq.push_back(1);
                wrs.push_back(int'(bus.dq_o));
            end
            prev_rd = bus.rd_n; prev_wr = bus.wr_n;
            bus.dq_i = 8'($urandom);
        end
        check("t4_num_acc", 32'(seq.size() >= 10), 32'd1);
        for (int k = 0; k < 10; k++)
            if (k < seq.size()) check("t4_pattern", seq[k], exp_seq[k]);
        if (wrs.size() > 0) check("t4_wr_data", wrs[0], 32'h5A);

        // 5: flow control
        do_reset();
        bus.tx0_valid = 1'b1; bus.tx0_data = 8'h3C; bus.txe_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.wr_n || bus.tx0_ready) cnt++;
        end
        check("t5_no_wr", cnt, 0);
        bus.txe_n = 1'b0; lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.tx0_ready && lat < 0) begin
                lat = i;
                bus.tx0_valid = 1'b0;
            end
        end
        check("t5_wr_latency", lat, 3);
        repeat (4) @(negedge clk);
        bus.rxf_n = 1'b0; bus.rx_ready = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.rd_n) cnt++;
        end
        check("t5_no_rd", cnt, 0);
        bus.rx_ready = 1'b1; lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!bus.rd_n && lat < 0) begin
                lat = i;
                bus.rxf_n = 1'b1;
            end
        end
        check("t5_rd_latency", lat, 1);
        repeat (8) @(negedge clk);

        // 6: reset during a write, then the held request is served afresh
        do_reset();
        bus.tx0_valid = 1'b1; bus.tx0_data = 8'h77; bus.txe_n = 1'b0;
        for (int i = 0; i < 10 && bus.wr_n; i++) @(negedge clk);
        check("t6_wr_reached", 32'(bus.wr_n), 32'd0);
        #2 n_rst = 1'b0;
        #1;
        check("t6_rst_wr_n", 32'(bus.wr_n), 32'd1);
        check("t6_rst_oe",   32'(bus.oe),   32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        cnt = 0; got = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.tx0_ready) cnt++;
            if (!bus.wr_n) got = bus.dq_o;
        end
        check("t6_ready_again", cnt, 1);
        check("t6_resent", 32'(got), 32'h77);

        // Randomized traffic in phases with different flag/valid densities
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin rxf_p = 50; txe_p = 50; rdy_p = 70; val_p = 40; end
                1:       begin rxf_p = 90; txe_p = 80; rdy_p = 90; val_p = 80; end
                2:       begin rxf_p = 20; txe_p = 90; rdy_p = 50; val_p = 90; end
                default: begin rxf_p = 80; txe_p = 30; rdy_p = 30; val_p = 60; end
            endcase
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) bus.rxf_n = ($urandom_range(0, 99) >= rxf_p);
                if ($urandom_range(0, 3) == 0) bus.txe_n = ($urandom_range(0, 99) >= txe_p);
                bus.rx_ready = ($urandom_range(0, 99) < rdy_p);
                bus.dq_i     = 8'($urandom);
                requester(val_p, bus.tx0_ready, bus.tx0_valid, bus.tx0_data);
                requester(val_p, bus.tx1_ready, bus.tx1_valid, bus.tx1_data);
                if (c == 700) begin
                    #3 n_rst = 1'b0;
                    #4 n_rst = 1'b1;
                end
            end
        end
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
